ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx_if.sv | 29 ++
 rtl/ps2_host_tx.sv | 185 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if -- request/response bundle between a command source and the PS/2 host transmitter.
// Revision: 1.0
`default_nettype none

interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       done;
  logic       err;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  done,
    input  err
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output done,
    output err
  );
endinterface

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device byte transmitter (inhibit, start, 8 data, odd parity, stop, ack).
// Optional macro PS2_HOST_TX_TIMEOUT_EN adds a transfer timeout.  Revision: 1.0
`default_nettype none

module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  bus,
  input  logic          ps2_clk_i,
  input  logic          ps2_data_i,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  localparam int unsigned c_INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(INHIBIT_CYCLES - 1);

  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INHIBIT  = 3'd1,
    START    = 3'd2,
    SHIFT    = 3'd3,
    ACK      = 3'd4,
    WAITIDLE = 3'd5
  } state_t;

  state_t               state_q;
  logic [1:0]           clk_sync_q;
  logic [1:0]           data_sync_q;
  logic                 clk_prev_q;
  logic [c_INH_W-1:0]   inh_cnt_q;
  logic [c_INH_W-1:0]   inh_cnt_d;
  logic [3:0]           bit_cnt_q;
  logic [3:0]           bit_cnt_d;
  logic [7:0]           data_q;
  logic                 tx_ready_q;
  logic                 clk_oe_q;
  logic                 data_oe_q;
  logic                 done_q;
  logic                 err_q;
  logic                 w_fall;
  logic                 w_parity;
  logic                 w_timeout;

  assign w_fall    = clk_prev_q & ~clk_sync_q[1];
  assign w_parity  = ~^data_q;
  assign inh_cnt_d = inh_cnt_q + 1'b1;
  assign bit_cnt_d = bit_cnt_q + 4'd1;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int unsigned c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  logic [c_TO_W-1:0] to_cnt_q;
  logic [c_TO_W-1:0] to_cnt_d;

  assign to_cnt_d  = to_cnt_q + 1'b1;
  // The window closes once the acknowledge has been sampled (WAITIDLE is excluded).
  assign w_timeout = ((state_q == SHIFT) || (state_q == ACK)) && (to_cnt_q == c_TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      state_q     <= IDLE;
      tx_ready_q  <= 1'b1;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      inh_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      data_q      <= '0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[1];
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      if ((state_q == SHIFT) || (state_q == ACK)) begin
        to_cnt_q <= to_cnt_d;
      end else begin
        to_cnt_q <= '0;
      end
`endif
      if (w_timeout) begin
        state_q    <= IDLE;
        tx_ready_q <= 1'b1;
        clk_oe_q   <= 1'b0;
        data_oe_q  <= 1'b0;
        bit_cnt_q  <= '0;
        err_q      <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.tx_valid && tx_ready_q) begin
              data_q     <= bus.tx_data;
              state_q    <= INHIBIT;
              tx_ready_q <= 1'b0;
              clk_oe_q   <= 1'b1;
              data_oe_q  <= 1'b0;
              inh_cnt_q  <= '0;
            end
          end
          INHIBIT: begin
            if (inh_cnt_q == c_INH_LAST) begin
              state_q   <= START;
              data_oe_q <= 1'b1;
            end else begin
              inh_cnt_q <= inh_cnt_d;
            end
          end
          START: begin
            // Data stays low as the start bit until the device's first falling edge.
            state_q   <= SHIFT;
            clk_oe_q  <= 1'b0;
            bit_cnt_q <= '0;
          end
          SHIFT: begin
            if (w_fall) begin
              bit_cnt_q <= bit_cnt_d;
              if (bit_cnt_q < 4'd8) begin
                data_oe_q <= ~data_q[bit_cnt_q[2:0]];
              end else if (bit_cnt_q == 4'd8) begin
                data_oe_q <= ~w_parity;
              end else begin
                data_oe_q <= 1'b0;
                state_q   <= ACK;
              end
            end
          end
          ACK: begin
            if (w_fall) begin
              bit_cnt_q <= '0;
              if (!data_sync_q[1]) begin
                state_q <= WAITIDLE;
              end else begin
                state_q    <= IDLE;
                tx_ready_q <= 1'b1;
                err_q      <= 1'b1;
              end
            end
          end
          WAITIDLE: begin
            if (clk_sync_q[1] && data_sync_q[1]) begin
              state_q    <= IDLE;
              tx_ready_q <= 1'b1;
              done_q     <= 1'b1;
            end
          end
          default: begin
            state_q    <= IDLE;
            tx_ready_q <= 1'b1;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign ps2_clk_oe   = clk_oe_q;
  assign ps2_data_oe  = data_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- directed bench for ps2_host_tx with an open-collector PS/2 device model.
// Revision: 1.0
`default_nettype none

module tb_ps2_host_tx;

  localparam int unsigned c_INH  = 10000;
  localparam int unsigned c_TO   = 5000;
  localparam int          c_HALF = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  wire  ps2_clk_oe;
  wire  ps2_data_oe;
  wire  ps2_clk_line  = dev_clk & ~ps2_clk_oe;
  wire  ps2_data_line = dev_data & ~ps2_data_oe;

  int total = 0;
  int bad = 0;

  ps2_host_tx_if bus_if ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (c_INH),
    .TIMEOUT_CYCLES (c_TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if.slave),
    .ps2_clk_i   (ps2_clk_line),
    .ps2_data_i  (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  // Passive monitors: pulse counters and cycle stamps.
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0, start_cnt = 0;
  int last_rel = 0, last_err = 0;
  logic clk_oe_prev = 1'b0, err_prev = 1'b0, ready_after_err = 1'b0;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    clk_oe_prev <= ps2_clk_oe;
    err_prev    <= bus_if.err;
    if (bus_if.done) done_cnt <= done_cnt + 1;
    if (bus_if.err) err_cnt <= err_cnt + 1;
    if (bus_if.done && bus_if.err) both_cnt <= both_cnt + 1;
    if (ps2_clk_oe && !ps2_data_oe) inh_cnt <= inh_cnt + 1;
    if (ps2_clk_oe && ps2_data_oe) start_cnt <= start_cnt + 1;
    if (clk_oe_prev && !ps2_clk_oe) last_rel <= cyc;
    if (bus_if.err && !err_prev) last_err <= cyc;
    if (err_prev) ready_after_err <= bus_if.tx_ready;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog obs=time_expired exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int snap_done = 0, snap_err = 0, snap_inh = 0, snap_start = 0;

  task automatic snap();
    snap_done  = done_cnt;
    snap_err   = err_cnt;
    snap_inh   = inh_cnt;
    snap_start = start_cnt;
  endtask

  task automatic send(input logic [7:0] d);
    chk("ready_before_send", {31'd0, bus_if.tx_ready}, 32'd1);
    bus_if.tx_data  = d;
    bus_if.tx_valid = 1'b1;
    @(negedge clk);
    bus_if.tx_valid = 1'b0;
  endtask

  // Device side: waits for the host request, clocks n_edges falling edges,
  // sampling on each rising edge; edge 11 carries the (optional) acknowledge.
  task automatic dev_xfer(input int n_edges, input bit ack,
                          output logic [9:0] bits, output logic start_bit);
    int w;
    bits = '0;
    start_bit = 1'b1;
    w = 0;
    while (ps2_clk_oe !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    w = 0;
    while (ps2_clk_oe !== 1'b0 && w < int'(c_INH) + 100) begin @(negedge clk); w++; end
    chk("host_release", {31'd0, ps2_clk_oe}, 32'd0);
    if (ps2_clk_oe !== 1'b0) return;
    start_bit = ps2_data_line;
    for (int i = 0; i < 10 && i < n_edges; i++) begin
      repeat (c_HALF) @(negedge clk);
      dev_clk = 1'b0;
      repeat (c_HALF) @(negedge clk);
      dev_clk = 1'b1;
      bits[i] = ps2_data_line;
    end
    if (n_edges >= 11) begin
      repeat (c_HALF / 2) @(negedge clk);
      if (ack) dev_data = 1'b0;
      repeat (c_HALF / 2) @(negedge clk);
      dev_clk = 1'b0;
      repeat (c_HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (c_HALF) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_resp(input int lim);
    int w;
    w = 0;
    while ((done_cnt + err_cnt) == (snap_done + snap_err) && w < lim) begin
      @(negedge clk);
      w++;
    end
    chk("response_seen", {31'd0, (done_cnt + err_cnt) != (snap_done + snap_err)}, 32'd1);
    repeat (20) @(negedge clk);
  endtask

  logic [9:0] bits;
  logic       sbit;

  initial begin
    bus_if.tx_data  = 8'h00;
    bus_if.tx_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus_if.tx_ready}, 32'd1);
    chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    chk("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    chk("rst_done_err", {30'd0, bus_if.done, bus_if.err}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1
    snap();
    send(8'hED);
    dev_xfer(11, 1'b1, bits, sbit);
    wait_resp(2000);
    chk("ed_start_bit", {31'd0, sbit}, 32'd0);
    chk("ed_bits", {22'd0, bits}, 32'h3ED);
    chk("ed_done", done_cnt - snap_done, 32'd1);
    chk("ed_err", err_cnt - snap_err, 32'd0);

    // 0xF4: parity 0, inhibit length, single start cycle
    snap();
    send(8'hF4);
    dev_xfer(11, 1'b1, bits, sbit);
    wait_resp(2000);
    chk("f4_bits", {22'd0, bits}, 32'h2F4);
    chk("f4_inhibit_cycles", inh_cnt - snap_inh, c_INH);
    chk("f4_start_cycles", start_cnt - snap_start, 32'd1);
    chk("f4_done", done_cnt - snap_done, 32'd1);

    // Missing acknowledge
    snap();
    send(8'h5A);
    dev_xfer(11, 1'b0, bits, sbit);
    wait_resp(2000);
    chk("nack_err", err_cnt - snap_err, 32'd1);
    chk("nack_done", done_cnt - snap_done, 32'd0);
    chk("nack_ready_next", {31'd0, ready_after_err}, 32'd1);

    // Reset after edge 5
    snap();
    send(8'h3C);
    dev_xfer(5, 1'b1, bits, sbit);
    chk("pre_rst_busy", {31'd0, bus_if.tx_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    chk("midrst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    chk("postrst_ready", {31'd0, bus_if.tx_ready}, 32'd1);
    chk("postrst_pulses", (done_cnt - snap_done) + (err_cnt - snap_err), 32'd0);

    // tx_valid held with 0xAA while 0xED is in flight
    snap();
    bus_if.tx_data  = 8'hED;
    bus_if.tx_valid = 1'b1;
    @(negedge clk);
    bus_if.tx_data  = 8'hAA;
    repeat (5) @(negedge clk);
    chk("hold_busy", {31'd0, bus_if.tx_ready}, 32'd0);
    dev_xfer(11, 1'b1, bits, sbit);
    wait_resp(2000);
    chk("hold_first_bits", {22'd0, bits}, 32'h3ED);
    chk("hold_first_done", done_cnt - snap_done, 32'd1);
    chk("hold_aa_accepted", {31'd0, bus_if.tx_ready}, 32'd0);
    bus_if.tx_valid = 1'b0;
    snap();
    dev_xfer(11, 1'b1, bits, sbit);
    wait_resp(2000);
    chk("hold_aa_bits", {22'd0, bits}, 32'h3AA);
    chk("hold_aa_done", done_cnt - snap_done, 32'd1);

`ifdef PS2_HOST_TX_TIMEOUT_EN
    // Device stops after edge 3
    snap();
    send(8'h55);
    dev_xfer(3, 1'b1, bits, sbit);
    wait_resp(int'(c_TO) + 1000);
    chk("to_err", err_cnt - snap_err, 32'd1);
    chk("to_done", done_cnt - snap_done, 32'd0);
    chk("to_latency", last_err - last_rel, c_TO);
    chk("to_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
`endif

    chk("never_both", both_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
